// File: rtl/gsensor_pkg.sv
// Shared constants, state encodings and command-byte helper for the ADXL345 sequencer.
package gsensor_pkg;

  localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
  localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
  localparam logic [5:0] ADDR_INT_ENABLE  = 6'h2E;
  localparam logic [5:0] ADDR_INT_MAP     = 6'h2F;
  localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
  localparam logic [5:0] ADDR_DATAX0      = 6'h32;

  localparam int unsigned CMD_RW_BIT = 7;
  localparam int unsigned CMD_MB_BIT = 6;

  localparam logic [2:0] CFG_NBYTES  = 3'd2;
  localparam logic [2:0] READ_NBYTES = 3'd7;

  typedef enum logic [2:0] {STARTUP, CFG, IDLE, READ, DONE, GAP} state_e;

  typedef enum logic [1:0] {XferIdle, XferLead, XferLow, XferHigh} xfer_state_e;

  function automatic logic [7:0] spi_cmd(input logic rd, input logic mb, input logic [5:0] addr);
    logic [7:0] cmd;
    cmd             = {2'b00, addr};
    cmd[CMD_RW_BIT] = rd;
    cmd[CMD_MB_BIT] = mb;
    return cmd;
  endfunction

endpackage

// File: rtl/gsensor_spi_xfer.sv
// SPI mode-3 transaction engine: CS framing, SCLK generation, MSB-first shift in/out.
module gsensor_spi_xfer
  import gsensor_pkg::*;
#(
  parameter int unsigned HP = 12
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [2:0] nbytes_i,
  output logic       tx_req_o,
  output logic [2:0] tx_idx_o,
  input  logic [7:0] tx_byte_i,
  output logic [7:0] rx_byte_o,
  output logic [2:0] rx_idx_o,
  output logic       rx_valid_o,
  output logic       done_o,
  output logic       cs_n_o,
  output logic       sclk_o,
  output logic       mosi_o,
  input  logic       miso_i
);

  xfer_state_e st_q;
  logic [15:0] cnt_q;
  logic [3:0]  bit_q;
  logic [2:0]  byte_q, nb_q;
  logic [7:0]  tx_sh_q, rx_sh_q, rx_byte_q;
  logic [2:0]  rx_idx_q;
  logic        cs_n_q, sclk_q, mosi_q, rx_valid_q, done_q;
  logic        hp_end, last_byte;

  assign hp_end    = (cnt_q == 16'(HP - 1));
  assign last_byte = (byte_q == nb_q);
  // Parent answers a request combinationally with the byte at tx_idx_o.
  assign tx_req_o  = hp_end && ((st_q == XferLead) ||
                                (st_q == XferHigh && bit_q == 4'd8 && !last_byte));
  assign tx_idx_o  = byte_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q       <= XferIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      nb_q       <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_byte_q  <= '0;
      rx_idx_q   <= '0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b1;
      mosi_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= hp_end ? '0 : cnt_q + 16'd1;
      case (st_q)
        XferIdle: begin
          cnt_q <= '0;
          if (start_i) begin
            cs_n_q <= 1'b0;
            byte_q <= '0;
            bit_q  <= '0;
            nb_q   <= nbytes_i;
            st_q   <= XferLead;
          end
        end
        XferLead: begin
          if (hp_end) begin
            sclk_q  <= 1'b0;
            mosi_q  <= tx_byte_i[7];
            tx_sh_q <= {tx_byte_i[6:0], 1'b0};
            st_q    <= XferLow;
          end
        end
        XferLow: begin
          if (hp_end) begin
            sclk_q  <= 1'b1;
            rx_sh_q <= {rx_sh_q[6:0], miso_i};
            bit_q   <= bit_q + 4'd1;
            if (bit_q == 4'd7) begin
              rx_valid_q <= 1'b1;
              rx_byte_q  <= {rx_sh_q[6:0], miso_i};
              rx_idx_q   <= byte_q;
              byte_q     <= byte_q + 3'd1;
            end
            st_q <= XferHigh;
          end
        end
        XferHigh: begin
          if (hp_end) begin
            if (bit_q == 4'd8 && last_byte) begin
              cs_n_q <= 1'b1;
              mosi_q <= 1'b0;
              done_q <= 1'b1;
              st_q   <= XferIdle;
            end else if (bit_q == 4'd8) begin
              sclk_q  <= 1'b0;
              mosi_q  <= tx_byte_i[7];
              tx_sh_q <= {tx_byte_i[6:0], 1'b0};
              bit_q   <= '0;
              st_q    <= XferLow;
            end else begin
              sclk_q  <= 1'b0;
              mosi_q  <= tx_sh_q[7];
              tx_sh_q <= {tx_sh_q[6:0], 1'b0};
              st_q    <= XferLow;
            end
          end
        end
        default: st_q <= XferIdle;
      endcase
    end
  end

  assign rx_byte_o  = rx_byte_q;
  assign rx_idx_o   = rx_idx_q;
  assign rx_valid_o = rx_valid_q;
  assign done_o     = done_q;
  assign cs_n_o     = cs_n_q;
  assign sclk_o     = sclk_q;
  assign mosi_o     = mosi_q;

endmodule

// File: rtl/gsensor_ctrl.sv
// ADXL345 sequencer: power-up wait, config writes, periodic X/Y/Z burst reads.
// Define GSENSOR_INT_TRIGGER_EN to trigger reads from INT1 (DATA_READY) instead of a timer.
module gsensor_ctrl
  import gsensor_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned SCLK_HZ     = 2000000,
  parameter int unsigned STARTUP_CYC = 100000,
  parameter int unsigned SAMPLE_CYC  = 250000,
  parameter int unsigned GAP_CYC     = 24,
  parameter logic [7:0]  BW_RATE_VAL = 8'h0A,
  parameter logic [7:0]  FORMAT_VAL  = 8'h08
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_int1,
  output logic        o_cs_n,
  output logic        o_sclk,
  output logic        o_mosi,
  input  logic        i_miso,
  output logic [15:0] o_x,
  output logic [15:0] o_y,
  output logic [15:0] o_z,
  output logic        o_valid,
  output logic        o_cfg_done,
  output logic        o_busy
);

  localparam int unsigned HP = CLK_HZ / (2 * SCLK_HZ);
`ifdef GSENSOR_INT_TRIGGER_EN
  localparam logic [2:0] NUM_CFG = 3'd5;
`else
  localparam logic [2:0] NUM_CFG = 3'd3;
`endif

  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  state_e      state_q;
  logic [31:0] cnt_q;
  logic [2:0]  cfg_idx_q;
  logic        start_q, cfg_done_q, valid_q;
  logic [47:0] rd_q;
  logic [15:0] x_q, y_q, z_q;
  logic        trig;

  logic       tx_req, rx_valid, xdone, cs_n;
  logic [2:0] tx_idx, rx_idx;
  logic [7:0] tx_byte, rx_byte, cfg_data;
  logic [5:0] cfg_addr;

  always_comb begin
    cfg_addr = ADDR_DATA_FORMAT;
    cfg_data = FORMAT_VAL;
    case (cfg_idx_q)
      3'd1: begin cfg_addr = ADDR_BW_RATE;    cfg_data = BW_RATE_VAL; end
      3'd2: begin cfg_addr = ADDR_POWER_CTL;  cfg_data = 8'h08;       end
`ifdef GSENSOR_INT_TRIGGER_EN
      3'd3: begin cfg_addr = ADDR_INT_MAP;    cfg_data = 8'h00;       end
      3'd4: begin cfg_addr = ADDR_INT_ENABLE; cfg_data = 8'h80;       end
`endif
      default: ;
    endcase
  end

  always_comb begin
    tx_byte = 8'h00;
    if (tx_req && tx_idx == 3'd0) begin
      tx_byte = (state_q == READ) ? spi_cmd(1'b1, 1'b1, ADDR_DATAX0)
                                  : spi_cmd(1'b0, 1'b0, cfg_addr);
    end else if (tx_req && tx_idx == 3'd1 && state_q == CFG) begin
      tx_byte = cfg_data;
    end
  end

  gsensor_spi_xfer #(
    .HP (HP)
  ) u_xfer (
    .clk_i      (i_clk),
    .rst_ni     (rst_n),
    .start_i    (start_q),
    .nbytes_i   ((state_q == READ) ? READ_NBYTES : CFG_NBYTES),
    .tx_req_o   (tx_req),
    .tx_idx_o   (tx_idx),
    .tx_byte_i  (tx_byte),
    .rx_byte_o  (rx_byte),
    .rx_idx_o   (rx_idx),
    .rx_valid_o (rx_valid),
    .done_o     (xdone),
    .cs_n_o     (cs_n),
    .sclk_o     (o_sclk),
    .mosi_o     (o_mosi),
    .miso_i     (i_miso)
  );

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= STARTUP;
      cnt_q      <= '0;
      cfg_idx_q  <= '0;
      start_q    <= 1'b0;
      cfg_done_q <= 1'b0;
      valid_q    <= 1'b0;
      rd_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
    end else begin
      start_q <= 1'b0;
      valid_q <= 1'b0;
      case (state_q)
        STARTUP: begin
          if (cnt_q == STARTUP_CYC - 1) begin
            cnt_q   <= '0;
            state_q <= CFG;
            start_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        CFG:  if (xdone) state_q <= GAP;
        IDLE: begin
          if (trig) begin
            state_q <= READ;
            start_q <= 1'b1;
          end
        end
        READ: begin
          // Byte 0 is the command slot; bytes 1..6 are X0,X1,Y0,Y1,Z0,Z1.
          if (rx_valid && rx_idx != 3'd0) rd_q[{rx_idx - 3'd1, 3'b000} +: 8] <= rx_byte;
          if (xdone) state_q <= DONE;
        end
        DONE: begin
          x_q     <= rd_q[15:0];
          y_q     <= rd_q[31:16];
          z_q     <= rd_q[47:32];
          valid_q <= 1'b1;
          state_q <= GAP;
        end
        GAP: begin
          if (cnt_q == GAP_CYC - 1) begin
            cnt_q <= '0;
            if (cfg_done_q) begin
              state_q <= IDLE;
            end else if (cfg_idx_q == NUM_CFG - 3'd1) begin
              cfg_done_q <= 1'b1;
              state_q    <= IDLE;
            end else begin
              cfg_idx_q <= cfg_idx_q + 3'd1;
              state_q   <= CFG;
              start_q   <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        default: state_q <= STARTUP;
      endcase
    end
  end

`ifdef GSENSOR_INT_TRIGGER_EN
  logic [1:0] int_sync_q;

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) int_sync_q <= 2'b00;
    else        int_sync_q <= {int_sync_q[0], i_int1};
  end
  assign trig = int_sync_q[1];
`else
  logic [31:0] tmr_q;
  logic        pend_q, wrap, unused_int1;

  assign unused_int1 = i_int1;
  assign wrap        = cfg_done_q && (tmr_q == SAMPLE_CYC - 1);

  // Pending is consumed in IDLE; a wrap in the same cycle re-arms it.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      tmr_q  <= (!cfg_done_q || wrap) ? '0 : tmr_q + 32'd1;
      pend_q <= (pend_q && state_q != IDLE) || wrap;
    end
  end
  assign trig = pend_q;
`endif

  assign o_cs_n     = cs_n;
  assign o_x        = x_q;
  assign o_y        = y_q;
  assign o_z        = z_q;
  assign o_valid    = valid_q;
  assign o_cfg_done = cfg_done_q;
  assign o_busy     = !cs_n || (state_q == GAP);

endmodule

// File: tb/tb_gsensor_ctrl.sv
// Scoreboard bench for gsensor_ctrl: SPI slave model, timing checker, sample checker.
module tb_gsensor_ctrl;

  localparam int STARTUP = 100;
  localparam int SAMPLE  = 3000;
  localparam int GAPC    = 24;
  localparam int HP      = 12;
`ifdef GSENSOR_INT_TRIGGER_EN
  localparam int NUM_CFG = 5;
`else
  localparam int NUM_CFG = 3;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        int1 = 1'b0;
  logic        miso = 1'b0;
  logic        cs_n, sclk, mosi, valid, cfg_done, busy;
  logic [15:0] x, y, z;

  gsensor_ctrl #(
    .CLK_HZ      (50000000),
    .SCLK_HZ     (2000000),
    .STARTUP_CYC (STARTUP),
    .SAMPLE_CYC  (SAMPLE),
    .GAP_CYC     (GAPC),
    .BW_RATE_VAL (8'h0A),
    .FORMAT_VAL  (8'h08)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_int1     (int1),
    .o_cs_n     (cs_n),
    .o_sclk     (sclk),
    .o_mosi     (mosi),
    .i_miso     (miso),
    .o_x        (x),
    .o_y        (y),
    .o_z        (z),
    .o_valid    (valid),
    .o_cfg_done (cfg_done),
    .o_busy     (busy)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  logic [7:0]  exp_mosi[$];
  logic [47:0] exp_smp[$];

  task automatic push_cfg();
    exp_mosi.push_back(8'h31); exp_mosi.push_back(8'h08);
    exp_mosi.push_back(8'h2C); exp_mosi.push_back(8'h0A);
    exp_mosi.push_back(8'h2D); exp_mosi.push_back(8'h08);
`ifdef GSENSOR_INT_TRIGGER_EN
    exp_mosi.push_back(8'h2F); exp_mosi.push_back(8'h00);
    exp_mosi.push_back(8'h2E); exp_mosi.push_back(8'h80);
`endif
  endtask

  task automatic push_read_cmd();
    exp_mosi.push_back(8'hF2);
    for (int i = 0; i < 6; i++) exp_mosi.push_back(8'h00);
  endtask

  // Slave read data, byte order X0 X1 Y0 Y1 Z0 Z1.
  function automatic logic [47:0] slave_word(input int i);
    case (i & 3)
      0:       return 48'h3412_CDAB_0080;
      1:       return 48'hFF7F_0100_00FF;
      2:       return 48'h0080_FFFF_7856;
      default: return 48'hA5C3_3C5A_0000;
    endcase
  endfunction

  int          sbit = 0;
  int          sidx = 0;
  logic [55:0] stream;

  always @(negedge sclk or negedge cs_n) begin
    if (!cs_n) begin
      if (sclk) begin
        sbit = 0;
      end else begin
        stream = {8'h00, slave_word(sidx)};
        miso   = (sbit < 56) ? stream[55 - sbit] : 1'b0;
        sbit++;
      end
    end
  end

  // Only a complete 7-byte read advances the slave to its next data set.
  always @(posedge cs_n) if (sbit == 56) sidx++;

  int         cyc = 0;
  int         bits = 0, cfg_txn = 0, n_valid = 0, n_cs_fall = 0;
  int         t_cs_fall = 0, t_cs_rise = 0, t_fall = 0, t_rise = 0, t_read = 0;
  bit         have_cs_rise = 0, first_fall = 0, cur_is_read = 0, read_prev_ok = 0, vnext = 0;
  logic       p_cs = 1'b1, p_sclk = 1'b1, p_mosi = 1'b0, p_done = 1'b0;
  logic [7:0] sh = 8'h00;
  logic [7:0] eb;
  logic [47:0] es;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      bits = 0; cur_is_read = 0; have_cs_rise = 0; read_prev_ok = 0;
      cfg_txn = 0; vnext = 0; first_fall = 0;
    end else begin
      if (vnext) begin
        check(!valid, "valid_width", valid, 0);
        vnext = 0;
      end else if (valid) begin
        if (exp_smp.size() == 0) begin
          check(0, "unexpected_valid", {x, y, z}, 0);
        end else begin
          es = exp_smp.pop_front();
          check({x, y, z} == es, "sample_xyz", {x, y, z}, es);
        end
        n_valid++;
        vnext = 1;
      end
      if (cfg_done && !p_done) begin
        check(cfg_txn == NUM_CFG, "cfg_txn_count", cfg_txn, NUM_CFG);
        check(cyc - t_cs_rise >= GAPC && cyc - t_cs_rise <= GAPC + 4, "cfg_done_after_gap",
              cyc - t_cs_rise, GAPC);
      end
      if (p_cs && !cs_n) begin
        if (have_cs_rise) check(cyc - t_cs_rise >= GAPC, "cs_high_gap", cyc - t_cs_rise, GAPC);
        t_cs_fall = cyc; first_fall = 1; bits = 0; cur_is_read = 0;
        n_cs_fall++;
      end
      if (!cs_n && p_sclk && !sclk) begin
        if (first_fall) check(cyc - t_cs_fall == HP, "cs_to_first_fall", cyc - t_cs_fall, HP);
        else            check(cyc - t_fall == 2 * HP, "sclk_period", cyc - t_fall, 2 * HP);
        t_fall = cyc; first_fall = 0;
      end
      if (!cs_n && !p_sclk && sclk) begin
        check(mosi == p_mosi, "mosi_stable_at_rise", mosi, p_mosi);
        t_rise = cyc;
        sh = {sh[6:0], mosi};
        bits++;
        if (bits % 8 == 0) begin
          if (exp_mosi.size() == 0) begin
            check(0, "unexpected_mosi_byte", sh, 0);
          end else begin
            eb = exp_mosi.pop_front();
            check(sh == eb, "mosi_byte", sh, eb);
          end
          if (bits == 8 && sh == 8'hF2) begin
            cur_is_read = 1;
`ifndef GSENSOR_INT_TRIGGER_EN
            if (read_prev_ok) check(t_cs_fall - t_read == SAMPLE, "read_spacing",
                                    t_cs_fall - t_read, SAMPLE);
            t_read = t_cs_fall; read_prev_ok = 1;
`endif
          end
        end
      end
      if (!p_cs && cs_n) begin
        check(cyc - t_rise == HP, "last_rise_to_cs", cyc - t_rise, HP);
        check(sclk == 1'b1, "sclk_idle_high", sclk, 1);
        if (bits == 16 && !cur_is_read) cfg_txn++;
        t_cs_rise = cyc; have_cs_rise = 1;
      end
    end
    p_cs = cs_n; p_sclk = sclk; p_mosi = mosi; p_done = cfg_done;
  end

  task automatic check_reset_outputs(input string tag);
    check(cs_n == 1'b1, {tag, "_cs_n"}, cs_n, 1);
    check(sclk == 1'b1, {tag, "_sclk"}, sclk, 1);
    check(mosi == 1'b0, {tag, "_mosi"}, mosi, 0);
    check({x, y, z} == 48'h0, {tag, "_xyz"}, {x, y, z}, 0);
    check(valid == 1'b0, {tag, "_valid"}, valid, 0);
    check(cfg_done == 1'b0, {tag, "_cfg_done"}, cfg_done, 0);
    check(busy == 1'b0, {tag, "_busy"}, busy, 0);
  endtask

  int k;
  int snap;

  initial begin
    push_cfg();
    for (int i = 0; i < 3; i++) push_read_cmd();
    exp_smp.push_back(48'h1234_ABCD_8000);
    exp_smp.push_back(48'h7FFF_0001_FF00);

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
`ifdef GSENSOR_INT_TRIGGER_EN
    int1 = 1'b1;
`endif
    k = 0;
    while (cs_n && k < 400) begin @(negedge clk); k++; end
    check(!cs_n && k >= STARTUP && k <= STARTUP + 6, "startup_delay", k, STARTUP);

    k = 0;
    while (n_valid < 2 && k < 20000) begin @(negedge clk); k++; end
    check(n_valid >= 2, "wait_first_reads", n_valid, 2);

    // Cut the next read while its third byte is on the wire.
    k = 0;
    while (!(cur_is_read && bits >= 20 && !cs_n) && k < 8000) begin @(negedge clk); k++; end
    check(cur_is_read && bits >= 20, "wait_read_byte3", bits, 20);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("cut");

    exp_mosi.delete();
    push_cfg();
    for (int i = 0; i < 2; i++) push_read_cmd();
    exp_smp.push_back(48'h8000_FFFF_5678);
    exp_smp.push_back(48'hC3A5_5A3C_0000);
    repeat (5) @(negedge clk);
    check(n_valid == 2, "no_valid_on_cut", n_valid, 2);
    rst_n = 1'b1;

    k = 0;
    while (n_valid < 4 && k < 15000) begin @(negedge clk); k++; end
    check(n_valid >= 4, "wait_reads_after_reset", n_valid, 4);
    repeat (2) @(negedge clk);

`ifdef GSENSOR_INT_TRIGGER_EN
    int1 = 1'b0;
    snap = n_cs_fall;
    repeat (3000) @(negedge clk);
    check(n_cs_fall == snap, "no_read_int_low", n_cs_fall, snap);
`endif

    check(exp_mosi.size() == 0, "mosi_bytes_left", exp_mosi.size(), 0);
    check(exp_smp.size() == 0, "samples_left", exp_smp.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gsensor_ctrl.md
Name: gsensor_ctrl

Overview:
- Sequencer for the on-board ADXL345 accelerometer over 4-wire SPI, mode 3.
- After reset it waits for sensor power-up, then writes the configuration registers.
- It then repeatedly burst-reads DATAX0..DATAZ1 and presents signed X/Y/Z samples with a one-cycle valid strobe.
- Sits between the top-level GSENSOR pins and game logic. The top level owns the inout pad tristating; this block uses separate MOSI/MISO.

Parameters:
- CLK_HZ, 50000000, system clock frequency.
- SCLK_HZ, 2000000, SPI clock. Half-period HP = CLK_HZ/(2*SCLK_HZ) cycles, must be ≥2 (default 12).
- STARTUP_CYC, 100000, cycles from reset release to first transaction.
- SAMPLE_CYC, 250000, read period in timer-trigger mode.
- GAP_CYC, 24, minimum CS-high cycles between transactions.
- BW_RATE_VAL, 8'h0A, value written to BW_RATE (0x2C).
- FORMAT_VAL, 8'h08, value written to DATA_FORMAT (0x31): full-res, ±2g, 4-wire.

Ports:
- i_clk  in  1  system clock (50 MHz).
- i_rst_n  in  1  asynchronous active-low reset.
- i_int1  in  1  sensor INT1, asynchronous; synchronised by two flops.
- o_cs_n  out  1  SPI chip select, active low.
- o_sclk  out  1  SPI clock, idles high.
- o_mosi  out  1  to sensor SDI.
- i_miso  in  1  from sensor SDO.
- o_x  out  16  signed X sample, {DATAX1,DATAX0}.
- o_y  out  16  signed Y sample.
- o_z  out  16  signed Z sample.
- o_valid  out  1  one-cycle pulse; o_x/o_y/o_z updated in this same cycle.
- o_cfg_done  out  1  high once configuration is complete; stays high until reset.
- o_busy  out  1  high while o_cs_n is low or the GAP phase is counting.

Behaviour:
- Reset (async assert, sync deassert internally):
  - o_cs_n=1, o_sclk=1, o_mosi=0.
  - o_x/o_y/o_z=0, o_valid=0, o_cfg_done=0, o_busy=0.
  - FSM returns to STARTUP, all counters cleared.
- FSM states and transitions:
  - STARTUP: count STARTUP_CYC, then CFG.
  - CFG: issue write list in order; each write is a 2-byte transaction {addr[5:0] with R/W=0, MB=0; data}, followed by GAP. List: 0x31←FORMAT_VAL, 0x2C←BW_RATE_VAL, 0x2D←8'h08 (measure).
  - After the last GAP: o_cfg_done←1, go to IDLE.
  - IDLE: on trigger, go to READ.
  - READ: 7-byte transaction. Command byte 0xF2 (R=1, MB=1, addr 0x32), then 6 dummy 0x00 bytes. Received bytes 1..6 captured as X0,X1,Y0,Y1,Z0,Z1.
  - After READ: one cycle in DONE, which loads the outputs and pulses o_valid, then GAP, then IDLE.
- SPI timing per transaction:
  - o_cs_n falls; HP cycles later the first o_sclk fall; MSB first.
  - o_mosi changes only on the o_sclk falling edge. i_miso is sampled on the o_sclk rising edge.
  - 8 rising edges per byte. Bytes are back-to-back with no extra gap.
  - HP cycles after the last rising edge, o_cs_n rises. GAP then holds o_cs_n high for GAP_CYC cycles.
- Trigger (macro absent):
  - Free-running counter starts at 0 when o_cfg_done rises and wraps at SAMPLE_CYC-1; the wrap raises a pending flag.
  - A wrap while busy sets pending. Multiple wraps coalesce into one read; none is lost entirely.
  - IDLE with pending set: clear pending and start READ.
- Output registers hold their value between strobes.
- o_valid never pulses for a transaction cut by reset.

Optional Feature:
- Macro GSENSOR_INT_TRIGGER_EN.
- Defined:
  - Two extra config writes are appended after 0x2D: 0x2F←8'h00 (all interrupts to INT1), then 0x2E←8'h80 (DATA_READY enable).
  - Trigger is the synchronised i_int1 level high while in IDLE (level-sensitive; the sensor clears INT on data read). The timer is not instantiated.
- Undefined: timer trigger as above; i_int1 is ignored; 3 config writes.

Decomposition:
- Package gsensor_pkg holds:
  - Register address constants (0x2C, 0x2D, 0x2E, 0x2F, 0x31, 0x32).
  - Command-bit constants RW=bit7, MB=bit6.
  - FSM state enum {STARTUP, CFG, IDLE, READ, DONE, GAP}.
  - Byte-count constants 2 and 7.
- Sub-module gsensor_spi_xfer: given start, byte count and a tx-byte request/ack, it drives CS/SCLK/MOSI, returns rx bytes with a byte-done strobe, and asserts done after CS rises.

Test Plan:
- Reset release, defaults, STARTUP_CYC=100 → after 100 cycles there are three transactions, MOSI 0x31 0x08 | 0x2C 0x0A | 0x2D 0x08; o_cfg_done rises after the third GAP.
- SPI timing checker → SCLK period 24 cycles, idle high. CS-low to first SCLK fall is 12 cycles. MOSI is stable across every rising edge. CS high is ≥24 cycles between transactions.
- Slave model returns 0x34,0x12,0xCD,0xAB,0x00,0x80 → command 0xF2; o_x=16'h1234, o_y=16'hABCD, o_z=16'h8000; o_valid high exactly 1 cycle.
- SAMPLE_CYC=5000, no macro → READ transactions start 5000 cycles apart. SAMPLE_CYC=100 (shorter than a read) → reads run back-to-back separated by GAP only, one per completion.
- i_rst_n asserted during byte 3 of READ → o_cs_n=1 and o_sclk=1 immediately; no o_valid; outputs 0; after release, STARTUP/CFG repeats.
- Macro defined → five config writes ending 0x2F 0x00, 0x2E 0x80. i_int1 held high → reads repeat continuously. i_int1 low → no reads.
